// File: rtl/cov_nbmb_gearbox_pkg.sv
// Shared types and sizing helpers for the N-bit to M-bit transmit gearbox.
package cov_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } gb_state_e;

  // Bit buffer depth: room for two of the wider word, so that a full
  // output word plus one incoming word always fits.
  function automatic int calc_buf_w(input int in_w, input int out_w);
    return 2 * ((in_w > out_w) ? in_w : out_w);
  endfunction

  // Width of a counter that can hold 0..buf_w inclusive.
  function automatic int calc_fill_w(input int buf_w);
    return $clog2(buf_w + 1);
  endfunction

endpackage

// File: rtl/cov_nbmb_gearbox_if.sv
// Stream interface of the gearbox: IN_W-bit words in, OUT_W-bit words out.
//
// Handshake: a word moves on a rising sys_clk edge exactly when valid and
// ready are both 1 in that cycle. A source holds data/last/valid stable
// until the transfer; ready never depends combinationally on valid.
interface cov_nbmb_gearbox_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3
) ();
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  // Gearbox side
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  // Upstream source / downstream sink side
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/cov_nbmb_gearbox_bitbuf.sv
// Bit buffer of the gearbox: owns the LSB-aligned bit store and its fill
// count. A pop is applied before a push in the same cycle, so the incoming
// word always lands directly above the bits that remain.
module cov_nbmb_bitbuf
  import cov_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 3,
  parameter int BUF_W  = 8,
  parameter int FILL_W = 4
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              push,
  input  logic [IN_W-1:0]   push_data,
  input  logic              pop,
  output logic [OUT_W-1:0]  buf_low,
  output logic [FILL_W-1:0] fill_q
);

  logic [BUF_W-1:0]  buf_q;
  logic [BUF_W-1:0]  buf_popped;
  logic [BUF_W-1:0]  buf_next;
  logic [FILL_W-1:0] fill_popped;
  logic [FILL_W-1:0] fill_next;

  // Pop-then-push: shift out one word (a short final word empties the
  // buffer), then OR the new word in at the new fill level. Bits at or
  // above fill are always zero, so the OR never corrupts stored bits.
  always_comb begin
    buf_popped  = buf_q;
    fill_popped = fill_q;
    if (pop) begin
      buf_popped  = buf_q >> OUT_W;
      fill_popped = (fill_q > FILL_W'(OUT_W)) ? (fill_q - FILL_W'(OUT_W)) : '0;
    end
    buf_next  = buf_popped;
    fill_next = fill_popped;
    if (push) begin
      buf_next  = buf_popped | (BUF_W'(push_data) << fill_popped);
      fill_next = fill_popped + FILL_W'(IN_W);
    end
  end

  // Buffer and fill registers; reset discards everything buffered.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_next;
      fill_q <= fill_next;
    end
  end

  assign buf_low = buf_q[OUT_W-1:0];

endmodule

// File: rtl/cov_nbmb_gearbox.sv
// N-bit to M-bit transmit gearbox: repacks IN_W-bit words into OUT_W-bit
// words LSB-first with valid/ready on both sides.
// Build option: define COV_NBMB_FLUSH_EN to enable frame-end handling
// (in_last, out_last, FLUSH state, padding of the final partial word).
// Without it the stream is continuous and partial bits carry over.
module cov_nbmb_gearbox
  import cov_pkg::*;
#(
  parameter int   IN_W    = 4,
  parameter int   OUT_W   = 3,
  parameter logic PAD_BIT = 1'b0,
  localparam int  BUF_W   = calc_buf_w(IN_W, OUT_W),
  localparam int  FILL_W  = calc_fill_w(BUF_W)
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  cov_nbmb_gearbox_if.slave    bus,
  output gb_state_e            dbg_state,
  output logic [FILL_W-1:0]    dbg_fill
);

  gb_state_e         state_q;
  logic [FILL_W-1:0] fill_q;
  logic [OUT_W-1:0]  buf_low;
  logic [OUT_W-1:0]  out_word;
  logic              in_ready;
  logic              out_valid;
  logic              out_last;
  logic              accept;
  logic              pop;

  // Flow control is a function of registers only: no path from out_ready.
  assign in_ready = (state_q != FLUSH) && (fill_q <= FILL_W'(BUF_W - IN_W));
  assign accept   = bus.in_valid && in_ready;
  assign pop      = out_valid && bus.out_ready;

`ifdef COV_NBMB_FLUSH_EN
  assign out_valid = (fill_q >= FILL_W'(OUT_W)) || ((state_q == FLUSH) && (fill_q != '0));
  assign out_last  = (state_q == FLUSH) && (fill_q <= FILL_W'(OUT_W)) && (fill_q != '0);
`else
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
  assign out_valid      = (fill_q >= FILL_W'(OUT_W));
  assign out_last       = 1'b0;
`endif

  // Output word: bit positions not backed by buffered data read as PAD_BIT.
  always_comb begin
    out_word = '0;
    for (int i = 0; i < OUT_W; i++) begin
      out_word[i] = (i < int'(fill_q)) ? buf_low[i] : PAD_BIT;
    end
  end

  // Frame FSM: a last word moves to FLUSH; the final (possibly padded) pop
  // returns to RUN. Without frame handling the block never leaves RUN.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
`ifdef COV_NBMB_FLUSH_EN
      case (state_q)
        RUN:   if (accept && bus.in_last) state_q <= FLUSH;
        FLUSH: if (pop && (fill_q <= FILL_W'(OUT_W))) state_q <= RUN;
      endcase
`else
      state_q <= RUN;
`endif
    end
  end

  cov_nbmb_bitbuf #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .BUF_W  (BUF_W),
    .FILL_W (FILL_W)
  ) u_bitbuf (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .push      (accept),
    .push_data (bus.in_data),
    .pop       (pop),
    .buf_low   (buf_low),
    .fill_q    (fill_q)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_data  = out_word;
  assign dbg_state     = state_q;
  assign dbg_fill      = fill_q;

endmodule

// File: tb/tb_cov_nbmb_gearbox.sv
// Directed bench for cov_nbmb_gearbox: a 4->3 instance and a 3->4 instance.
// Expected words are hand-derived from the LSB-first bit stream and held as
// {last, data} entries in per-instance expected queues.
module tb_cov_nbmb_gearbox;
  import cov_pkg::*;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 sys_clk = ~sys_clk;

  cov_nbmb_gearbox_if #(.IN_W(4), .OUT_W(3)) a_if ();
  cov_nbmb_gearbox_if #(.IN_W(3), .OUT_W(4)) b_if ();

  gb_state_e  a_state, b_state;
  logic [3:0] a_fill, b_fill;

  cov_nbmb_gearbox #(.IN_W(4), .OUT_W(3), .PAD_BIT(1'b0)) u_a (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .bus       (a_if),
    .dbg_state (a_state),
    .dbg_fill  (a_fill)
  );

  cov_nbmb_gearbox #(.IN_W(3), .OUT_W(4), .PAD_BIT(1'b0)) u_b (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .bus       (b_if),
    .dbg_state (b_state),
    .dbg_fill  (b_fill)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  int         peak_a   = 0;
  logic [3:0] exp_a_q[$];
  logic [4:0] exp_b_q[$];
  logic [3:0] exp_a_e;
  logic [4:0] exp_b_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on negedges; the monitor looks 1 time unit later, when
  // out_ready for the coming edge is settled.
  always @(negedge sys_clk) begin
    #1;
    if (!rst && a_if.out_valid && a_if.out_ready) begin
      chk("a_word_expected", 32'(exp_a_q.size() != 0), 32'd1);
      if (exp_a_q.size() != 0) begin
        exp_a_e = exp_a_q.pop_front();
        chk("a_word", {28'b0, a_if.out_last, a_if.out_data}, {28'b0, exp_a_e});
      end
    end
    if (!rst && b_if.out_valid && b_if.out_ready) begin
      chk("b_word_expected", 32'(exp_b_q.size() != 0), 32'd1);
      if (exp_b_q.size() != 0) begin
        exp_b_e = exp_b_q.pop_front();
        chk("b_word", {27'b0, b_if.out_last, b_if.out_data}, {27'b0, exp_b_e});
      end
    end
    if (!rst && int'(a_fill) > peak_a) peak_a = int'(a_fill);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Offers one word from a negedge and returns on the negedge after the
  // edge that accepted it.
  task automatic send_a(input logic [3:0] d, input logic l);
    logic took;
    took = 1'b0;
    a_if.in_data  = d;
    a_if.in_last  = l;
    a_if.in_valid = 1'b1;
    for (int t = 0; t < 40 && !took; t++) begin
      took = a_if.in_ready;
      @(negedge sys_clk);
    end
    a_if.in_valid = 1'b0;
    a_if.in_last  = 1'b0;
    chk("a_send_accept", {31'b0, took}, 32'd1);
  endtask

  task automatic send_b(input logic [2:0] d, input logic l);
    logic took;
    took = 1'b0;
    b_if.in_data  = d;
    b_if.in_last  = l;
    b_if.in_valid = 1'b1;
    for (int t = 0; t < 40 && !took; t++) begin
      took = b_if.in_ready;
      @(negedge sys_clk);
    end
    b_if.in_valid = 1'b0;
    b_if.in_last  = 1'b0;
    chk("b_send_accept", {31'b0, took}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    a_if.in_data = '0; a_if.in_valid = 1'b0; a_if.in_last = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_data = '0; b_if.in_valid = 1'b0; b_if.in_last = 1'b0; b_if.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_a_fill",      32'(a_fill), 32'd0);
    chk("rst_a_state",     32'(a_state), 32'(RUN));
    chk("rst_a_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("rst_a_out_last",  32'(a_if.out_last), 32'd0);
    chk("rst_a_out_data",  32'(a_if.out_data), 32'd0);
    chk("rst_a_in_ready",  32'(a_if.in_ready), 32'd1);
    chk("rst_b_fill",      32'(b_fill), 32'd0);
    chk("rst_b_out_valid", 32'(b_if.out_valid), 32'd0);
    chk("rst_b_in_ready",  32'(b_if.in_ready), 32'd1);

    // Exact multiple: A,5,3 -> 2,3,5,1 (no padding)
    a_if.out_ready = 1'b1;
`ifdef COV_NBMB_FLUSH_EN
    exp_a_q.push_back(4'h2); exp_a_q.push_back(4'h3);
    exp_a_q.push_back(4'h5); exp_a_q.push_back(4'h9);
    send_a(4'hA, 1'b0);
    chk("lat_a_out_valid", 32'(a_if.out_valid), 32'd1);
    chk("lat_a_out_data",  32'(a_if.out_data), 32'd2);
    send_a(4'h5, 1'b0);
    send_a(4'h3, 1'b1);
    chk("exact_state_flush", 32'(a_state), 32'(FLUSH));
`else
    exp_a_q.push_back(4'h2); exp_a_q.push_back(4'h3);
    exp_a_q.push_back(4'h5); exp_a_q.push_back(4'h1);
    send_a(4'hA, 1'b1);
    chk("lat_a_out_valid", 32'(a_if.out_valid), 32'd1);
    chk("lat_a_out_data",  32'(a_if.out_data), 32'd2);
    send_a(4'h5, 1'b0);
    send_a(4'h3, 1'b1);
    chk("exact_state_run", 32'(a_state), 32'(RUN));
`endif
    chk("exact_fill6",     32'(a_fill), 32'd6);
    chk("exact_in_ready0", 32'(a_if.in_ready), 32'd0);
    cyc(4);
    chk("exact_fill0",     32'(a_fill), 32'd0);
    chk("exact_q_empty",   32'(exp_a_q.size()), 32'd0);

`ifdef COV_NBMB_FLUSH_EN
    // Flush/pad: F,F(last) -> 7,7,3(last, padded)
    exp_a_q.push_back(4'h7); exp_a_q.push_back(4'h7); exp_a_q.push_back(4'hB);
    send_a(4'hF, 1'b0);
    send_a(4'hF, 1'b1);
    chk("flush_state",     32'(a_state), 32'(FLUSH));
    chk("flush_in_ready0", 32'(a_if.in_ready), 32'd0);
    chk("flush_fill5",     32'(a_fill), 32'd5);
    chk("flush_no_last",   32'(a_if.out_last), 32'd0);
    @(negedge sys_clk);
    chk("flush_pad_data",  32'(a_if.out_data), 32'd3);
    chk("flush_pad_last",  32'(a_if.out_last), 32'd1);
    chk("flush_pad_valid", 32'(a_if.out_valid), 32'd1);
    chk("flush_pad_rdy0",  32'(a_if.in_ready), 32'd0);
    @(negedge sys_clk);
    chk("flush_done_rdy",   32'(a_if.in_ready), 32'd1);
    chk("flush_done_state", 32'(a_state), 32'(RUN));
    chk("flush_done_fill",  32'(a_fill), 32'd0);
`else
    // Carry: F(last),1(last) -> 7,3 with 2 bits left waiting; 6 -> 0,3
    exp_a_q.push_back(4'h7); exp_a_q.push_back(4'h3);
    send_a(4'hF, 1'b1);
    send_a(4'h1, 1'b1);
    @(negedge sys_clk);
    chk("carry_fill2",     32'(a_fill), 32'd2);
    chk("carry_no_valid",  32'(a_if.out_valid), 32'd0);
    chk("carry_no_last",   32'(a_if.out_last), 32'd0);
    chk("carry_state_run", 32'(a_state), 32'(RUN));
    chk("carry_in_ready",  32'(a_if.in_ready), 32'd1);
    exp_a_q.push_back(4'h0); exp_a_q.push_back(4'h3);
    send_a(4'h6, 1'b0);
    cyc(3);
    chk("carry_fill0",     32'(a_fill), 32'd0);
    chk("carry_q_empty",   32'(exp_a_q.size()), 32'd0);
`endif

    // Backpressure: out_ready low for 6 cycles while input keeps offering
    a_if.out_ready = 1'b0;
    exp_a_q.push_back(4'h4); exp_a_q.push_back(4'h3); exp_a_q.push_back(4'h2);
    exp_a_q.push_back(4'h1); exp_a_q.push_back(4'h7); exp_a_q.push_back(4'h2);
    exp_a_q.push_back(4'h1); exp_a_q.push_back(4'h7);
    send_a(4'hC, 1'b0);
    send_a(4'h9, 1'b0);
    chk("bp_fill8",      32'(a_fill), 32'd8);
    chk("bp_in_ready0",  32'(a_if.in_ready), 32'd0);
    chk("bp_out_valid",  32'(a_if.out_valid), 32'd1);
    chk("bp_out_data",   32'(a_if.out_data), 32'd4);
    a_if.in_data  = 4'h2;
    a_if.in_valid = 1'b1;
    cyc(4);
    chk("bp_hold_fill",  32'(a_fill), 32'd8);
    chk("bp_hold_data",  32'(a_if.out_data), 32'd4);
    chk("bp_hold_valid", 32'(a_if.out_valid), 32'd1);
    a_if.out_ready = 1'b1;
    send_a(4'h2, 1'b0);
    send_a(4'h7, 1'b0);
    send_a(4'h5, 1'b0);
    send_a(4'hE, 1'b0);
    cyc(8);
    chk("bp_fill0",      32'(a_fill), 32'd0);
    chk("bp_q_empty",    32'(exp_a_q.size()), 32'd0);
    chk("bp_peak_fill",  32'(peak_a), 32'd8);

    // Reset mid-frame with 5 bits buffered
    exp_a_q.push_back(4'h7);
    send_a(4'hF, 1'b0);
    send_a(4'hF, 1'b1);
    chk("mid_fill5", 32'(a_fill), 32'd5);
`ifdef COV_NBMB_FLUSH_EN
    chk("mid_state_flush", 32'(a_state), 32'(FLUSH));
`endif
    a_if.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    chk("mid_rst_fill",      32'(a_fill), 32'd0);
    chk("mid_rst_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("mid_rst_out_last",  32'(a_if.out_last), 32'd0);
    chk("mid_rst_in_ready",  32'(a_if.in_ready), 32'd1);
    chk("mid_rst_state",     32'(a_state), 32'(RUN));
    chk("mid_rst_q_empty",   32'(exp_a_q.size()), 32'd0);
    a_if.out_ready = 1'b1;
`ifdef COV_NBMB_FLUSH_EN
    exp_a_q.push_back(4'h6); exp_a_q.push_back(4'h6); exp_a_q.push_back(4'h8);
    send_a(4'h6, 1'b0);
    send_a(4'h3, 1'b1);
`else
    exp_a_q.push_back(4'h6); exp_a_q.push_back(4'h6);
    exp_a_q.push_back(4'h0); exp_a_q.push_back(4'h0);
    send_a(4'h6, 1'b0);
    send_a(4'h3, 1'b1);
    send_a(4'h0, 1'b0);
`endif
    cyc(5);
    chk("new_frame_fill0",   32'(a_fill), 32'd0);
    chk("new_frame_q_empty", 32'(exp_a_q.size()), 32'd0);
    chk("new_frame_state",   32'(a_state), 32'(RUN));

    // Reverse ratio 3->4: 7,0,5,2 -> 7,4,5 (12 bits, exact)
    b_if.out_ready = 1'b1;
`ifdef COV_NBMB_FLUSH_EN
    exp_b_q.push_back(5'h07); exp_b_q.push_back(5'h04); exp_b_q.push_back(5'h15);
    send_b(3'h7, 1'b0);
    chk("rev_lat_no_valid", 32'(b_if.out_valid), 32'd0);
    send_b(3'h0, 1'b0);
    chk("rev_fill6",        32'(b_fill), 32'd6);
    chk("rev_first_data",   32'(b_if.out_data), 32'd7);
    send_b(3'h5, 1'b0);
    send_b(3'h2, 1'b1);
    chk("rev_state_flush",  32'(b_state), 32'(FLUSH));
`else
    exp_b_q.push_back(5'h07); exp_b_q.push_back(5'h04); exp_b_q.push_back(5'h05);
    send_b(3'h7, 1'b1);
    chk("rev_lat_no_valid", 32'(b_if.out_valid), 32'd0);
    send_b(3'h0, 1'b0);
    chk("rev_fill6",        32'(b_fill), 32'd6);
    chk("rev_first_data",   32'(b_if.out_data), 32'd7);
    send_b(3'h5, 1'b1);
    send_b(3'h2, 1'b0);
    chk("rev_state_run",    32'(b_state), 32'(RUN));
`endif
    cyc(5);
    chk("rev_fill0",   32'(b_fill), 32'd0);
    chk("rev_q_empty", 32'(exp_b_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
